clock_div_detector: RTL and testbench

//  Receive-side counterpart of the power-of-two clock divider. Measures a divided clock
//  (counter bit sel toggles every 2^sel clk cycles, so period 2^(sel+1) and 50% duty) and

---
 rtl/clock_div_detector.sv | 162 ++++++++++++++++
 tb/tb_clock_div_detector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_detector.sv
// clock_div_detector: measures a power-of-two divided clock, recovers its divider select and reports lock.
// Optional: define CLK_DIV_DET_SYNC_EN to put a 2-flop synchronizer in front of the div_in sampling register.

module clock_div_detector #(
    parameter int MAX_SEL  = 15,
    parameter int LOCK_CNT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               div_in,
    output logic [4:0]         sel_out,
    output logic               locked,
    output logic [MAX_SEL+1:0] period_out,
    output logic               meas_stb,
    output logic               err,
    output logic               timeout
);

    localparam int unsigned      CNT_W   = MAX_SEL + 2;
    localparam int unsigned      MATCH_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] MAX_P   = CNT_W'(1) << (MAX_SEL + 1);
    localparam logic [CNT_W-1:0] TO_CNT  = MAX_P + CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {SEEK, TRACK, LOCKED} state_t;

    state_t             state_q;
    logic               s_q, s_dly_q, samp, rise, legal;
    logic [CNT_W-1:0]   cnt_q, hcnt_q, cand_q, period_q;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [4:0]         sel_q, p_log2;
    logic               locked_q, stb_q, err_q, to_q;

`ifdef CLK_DIV_DET_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], div_in};
    end
    assign samp = sync_q[1];
`else
    assign samp = div_in;
`endif

    // NOTE: non-blocking assignments in every clocked block so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            s_q     <= samp;
            s_dly_q <= s_q;
        end
    end

    assign rise = s_q & ~s_dly_q;

    // Period and high-time counters restart on every rise; at the next rise they hold P and H.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt_q  <= '0;
            hcnt_q <= '0;
        end else if (rise) begin
            cnt_q  <= CNT_W'(1);
            hcnt_q <= CNT_W'(1);
        end else begin
            if (cnt_q != CNT_SAT)         cnt_q  <= cnt_q + CNT_W'(1);
            if (s_q && hcnt_q != CNT_SAT) hcnt_q <= hcnt_q + CNT_W'(1);
        end
    end

    // NOTE: every combinational output is given a default first so no latch is inferred.
    always_comb begin
        p_log2 = '0;
        for (int i = 0; i < int'(CNT_W); i++) begin
            if (cnt_q[i]) p_log2 = 5'(i);
        end
        legal = (cnt_q >= CNT_W'(2)) && (cnt_q <= MAX_P) &&
                ((cnt_q & (cnt_q - CNT_W'(1))) == '0) && (hcnt_q == (cnt_q >> 1));
        match_d = ((match_q == '0) || (cnt_q == cand_q)) ? match_q + MATCH_W'(1) : MATCH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEEK;
            match_q  <= '0;
            cand_q   <= '0;
            period_q <= '0;
            sel_q    <= '0;
            locked_q <= 1'b0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
            if (!en) begin
                state_q  <= SEEK;
                match_q  <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    SEEK: begin
                        if (rise) state_q <= TRACK;
                    end
                    TRACK: begin
                        if (rise) begin
                            stb_q    <= 1'b1;
                            period_q <= cnt_q;
                            if (!legal) begin
                                err_q   <= 1'b1;
                                match_q <= '0;
                            end else begin
                                match_q <= match_d;
                                cand_q  <= cnt_q;
                                if (match_d >= MATCH_W'(LOCK_CNT)) begin
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                    sel_q    <= p_log2 - 5'd1;
                                end
                            end
                        end else if (cnt_q == TO_CNT) begin
                            to_q    <= 1'b1;
                            match_q <= '0;
                            state_q <= SEEK;
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            stb_q    <= 1'b1;
                            period_q <= cnt_q;
                            if (!(legal && cnt_q == cand_q)) begin
                                err_q    <= 1'b1;
                                locked_q <= 1'b0;
                                state_q  <= TRACK;
                                match_q  <= legal ? MATCH_W'(1) : '0;
                                if (legal) cand_q <= cnt_q;
                            end
                        end else if (cnt_q == TO_CNT) begin
                            to_q     <= 1'b1;
                            locked_q <= 1'b0;
                            match_q  <= '0;
                            state_q  <= SEEK;
                        end
                    end
                    default: state_q <= SEEK;
                endcase
            end
        end
    end

    assign sel_out    = sel_q;
    assign locked     = locked_q;
    assign period_out = period_q;
    assign meas_stb   = stb_q;
    assign err        = err_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_clock_div_detector.sv
// tb_clock_div_detector: directed and randomized divided-clock stimulus, checked every cycle
// against a cycle-indexed reference model built from edge times and high-sample counts.

module tb_clock_div_detector;

    localparam int MAX_SEL  = 15;
    localparam int LOCK_CNT = 2;
    localparam int CNT_W    = MAX_SEL + 2;
    localparam int MAX_P    = 1 << (MAX_SEL + 1);
    localparam int TO_CYC   = MAX_P + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             div_in = 1'b0;
    logic [4:0]       sel_out;
    logic             locked;
    logic [CNT_W-1:0] period_out;
    logic             meas_stb, err, timeout;

    int checks = 0;
    int errors = 0;

    clock_div_detector #(.MAX_SEL(MAX_SEL), .LOCK_CNT(LOCK_CNT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_in(div_in),
        .sel_out(sel_out), .locked(locked), .period_out(period_out),
        .meas_stb(meas_stb), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: n is the index of the sample currently seen as s, last_rise the index of the last rise.
    int n = 0, last_rise = 0, high_cnt = 0, r_match = 0, r_cand = 0;
    bit r_s, r_sd, r_track, r_lock, sync0, sync1;
    int e_sel = 0, e_period = 0;
    bit e_locked, e_stb, e_err, e_to;

    task automatic model_step();
        bit rise, legal;
        int p;
        if (!rst_n) begin
            r_s = 0; r_sd = 0; sync0 = 0; sync1 = 0;
            r_track = 0; r_lock = 0; r_match = 0; r_cand = 0;
            e_sel = 0; e_period = 0; e_locked = 0; e_stb = 0; e_err = 0; e_to = 0;
            n++;
            return;
        end
        rise  = r_s && !r_sd;
        p     = n - last_rise;
        legal = (p >= 2) && (p <= MAX_P) && ((p & (p - 1)) == 0) && (high_cnt == p / 2);
        e_stb = 0; e_err = 0; e_to = 0;
        if (!en) begin
            r_track = 0; r_lock = 0; r_match = 0; e_locked = 0;
        end else if (!r_track && !r_lock) begin
            if (rise) r_track = 1;
        end else if (rise) begin
            e_stb = 1;
            e_period = p;
            if (r_lock) begin
                if (!(legal && p == r_cand)) begin
                    e_err = 1; e_locked = 0; r_lock = 0; r_track = 1;
                    r_match = legal ? 1 : 0;
                    if (legal) r_cand = p;
                end
            end else if (!legal) begin
                e_err = 1;
                r_match = 0;
            end else begin
                r_match = (r_match == 0 || p == r_cand) ? r_match + 1 : 1;
                r_cand = p;
                if (r_match >= LOCK_CNT) begin
                    r_track = 0; r_lock = 1; e_locked = 1;
                    e_sel = $clog2(p) - 1;
                end
            end
        end else if (p == TO_CYC) begin
            e_to = 1; e_locked = 0; r_match = 0; r_track = 0; r_lock = 0;
        end
        if (rise) begin
            last_rise = n;
            high_cnt = 1;
        end else if (r_s) begin
            high_cnt++;
        end
        r_sd = r_s;
`ifdef CLK_DIV_DET_SYNC_EN
        r_s = sync1;
        sync1 = sync0;
        sync0 = div_in;
`else
        r_s = div_in;
`endif
        n++;
    endtask

    task automatic step();
        logic [CNT_W+8:0] exp_v, got_v;
        model_step();
        @(posedge clk);
        #1;
        exp_v = {5'(e_sel), e_locked, CNT_W'(e_period), e_stb, e_err, e_to};
        got_v = {sel_out, locked, period_out, meas_stb, err, timeout};
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL cycle%0d got sel=%0d lk=%b per=%0d stb=%b err=%b to=%b exp sel=%0d lk=%b per=%0d stb=%b err=%b to=%b",
                   n, sel_out, locked, period_out, meas_stb, err, timeout,
                   e_sel, e_locked, e_period, e_stb, e_err, e_to);
        end
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic seg(input int h, input int l);
        div_in = 1'b1;
        repeat (h) step();
        div_in = 1'b0;
        repeat (l) step();
    endtask

    task automatic div_per(input int sel, input int k);
        repeat (k) seg(1 << sel, 1 << sel);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int sel, reps, h;
        // Reset state
        rst_n = 1'b0; en = 1'b1; div_in = 1'b0;
        repeat (2) step();
        check("reset_locked", int'(locked), 0);
        check("reset_period", int'(period_out), 0);
        rst_n = 1'b1;
        repeat (3) step();

        // sel=3: lock after third rise
        div_per(3, 3);
        check("sel3_locked", int'(locked), 1);
        check("sel3_sel", int'(sel_out), 3);
        check("sel3_period", int'(period_out), 16);

        // sel=0 from reset: fastest legal period
        do_reset();
        div_per(0, 8);
        check("sel0_locked", int'(locked), 1);
        check("sel0_sel", int'(sel_out), 0);
        check("sel0_period", int'(period_out), 2);

        // rate change while locked
        div_per(3, 4);
        div_per(5, 4);
        check("sel5_locked", int'(locked), 1);
        check("sel5_sel", int'(sel_out), 5);
        check("sel5_period", int'(period_out), 64);

        // non power-of-two period
        repeat (5) seg(6, 6);
        check("p12_locked", int'(locked), 0);
        check("p12_period", int'(period_out), 12);

        // timeout after lock, then reacquire
        div_per(2, 4);
        check("pre_to_locked", int'(locked), 1);
        div_in = 1'b0;
        repeat (TO_CYC + 3) step();
        check("to_locked", int'(locked), 0);
        check("to_sel_held", int'(sel_out), 2);
        div_per(2, 4);
        check("relock_sel2", int'(sel_out), 2);
        check("relock_locked", int'(locked), 1);

        // reset while locked
        do_reset();
        check("rst_locked", int'(locked), 0);
        check("rst_sel", int'(sel_out), 0);
        div_per(2, 3);
        check("rst_relock", int'(locked), 1);

        // randomized segments, with occasional bad duty, enable drops and resets
        for (int it = 0; it < 30; it++) begin
            sel  = int'($urandom_range(0, 6));
            reps = int'($urandom_range(1, 4));
            for (int r = 0; r < reps; r++) begin
                h = 1 << sel;
                if ($urandom_range(0, 5) == 0) h = h + 1;
                seg(h, 1 << sel);
            end
            case ($urandom_range(0, 7))
                0: begin
                    en = 1'b0;
                    repeat ($urandom_range(1, 5)) step();
                    en = 1'b1;
                end
                1: do_reset();
                default: ;
            endcase
        end
        div_per(4, 3);
        check("final_locked", int'(locked), 1);
        check("final_sel", int'(sel_out), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
